// File: rtl/shift_pkg.sv
// Shared constants for the shift execution unit: op encodings, FSM states, default width.
// Rotate support is selected by SHIFT_EXEC_ROTATE_EN in the files that import this package.
package shift_pkg;

    localparam int SHIFT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step used by shift_exec each SHIFT cycle.
// Rotate step exists only when SHIFT_EXEC_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] value,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        stepped = value;
        case (op)
            OP_SLL:  stepped = {value[WIDTH-2:0], 1'b0};
            OP_SRL:  stepped = {1'b0, value[WIDTH-1:1]};
            OP_SRA:  stepped = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_EXEC_ROTATE_EN
            OP_ROR:  stepped = {value[0], value[WIDTH-1:1]};
`endif
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/shift_exec.sv
// Multi-cycle shifter: one bit per clock, valid/ready on both sides, 3-state FSM.
// Rotate right (OP=11) is only executed when SHIFT_EXEC_ROTATE_EN is defined.
//
// Handshake: a request transfers on a rising CLK edge where IN_VALID && IN_READY;
// a result transfers on a rising edge where OUT_VALID && OUT_READY. OUT_VALID and
// RESULT do not change while waiting for OUT_READY.
module shift_exec
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OPERAND,
    input  logic [7:0]       AMOUNT,
    input  logic [1:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output state_e           DBG_STATE
);

    state_e           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [WIDTH-1:0] value_q, value_d;
    shift_op_e        op_q, op_d;

    shift_op_e        op_in;
    logic [7:0]       load_count;
    logic [WIDTH-1:0] stepped;

    assign op_in = shift_op_e'(OP);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (value_q),
        .op      (op_q),
        .stepped (stepped)
    );

    // Shifts clamp at WIDTH (everything shifted out); rotates wrap modulo WIDTH.
    always_comb begin
        load_count = (int'(AMOUNT) > WIDTH) ? 8'(WIDTH) : AMOUNT;
`ifdef SHIFT_EXEC_ROTATE_EN
        if (op_in == OP_ROR) load_count = 8'(int'(AMOUNT) % WIDTH);
`else
        if (op_in == OP_ROR) load_count = '0;
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            value_q <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            value_q <= value_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        value_d = value_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    value_d = OPERAND;
                    op_d    = op_in;
                    count_d = load_count;
                    state_d = (load_count == 8'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                value_d = stepped;
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == ST_IDLE);
        OUT_VALID = (state_q == ST_DONE);
        BUSY      = (state_q != ST_IDLE);
        RESULT    = value_q;
        DBG_STATE = state_q;
    end

endmodule

// File: tb/tb_shift_exec.sv
// Directed bench for shift_exec (WIDTH=8); ROR expectations follow SHIFT_EXEC_ROTATE_EN.
module tb_shift_exec;

    logic       CLK;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OPERAND;
    logic [7:0] AMOUNT;
    logic [1:0] OP;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] RESULT;
    logic       BUSY;
    logic [1:0] DBG_STATE;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    shift_exec #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OPERAND   (OPERAND),
        .AMOUNT    (AMOUNT),
        .OP        (OP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full transaction: present, accept, scramble inputs, wait for result, consume.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] operand,
                          input logic [7:0] amount, input logic [7:0] exp_res, input int exp_lat);
        int lat;
        logic [7:0] exp_v;
        exp_q.push_back(exp_res);
        check({tag, "_in_ready"}, {31'b0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        OP       = op;
        OPERAND  = operand;
        AMOUNT   = amount;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        OPERAND  = 8'($urandom_range(0, 255));
        AMOUNT   = 8'($urandom_range(0, 255));
        OP       = 2'($urandom_range(0, 3));
        if (exp_lat > 0) check({tag, "_state_shift"}, {30'b0, DBG_STATE}, 32'd1);
        else             check({tag, "_state_done"}, {30'b0, DBG_STATE}, 32'd2);
        lat = 0;
        while (!OUT_VALID && lat < 300) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_out_valid"}, {31'b0, OUT_VALID}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        exp_v = exp_q.pop_front();
        check({tag, "_result"}, {24'b0, RESULT}, {24'b0, exp_v});
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check({tag, "_idle_ready"}, {31'b0, IN_READY}, 32'd1);
        check({tag, "_idle_valid"}, {31'b0, OUT_VALID}, 32'd0);
    endtask

    initial begin
        int seen;
        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        OPERAND   = 8'h00;
        AMOUNT    = 8'h00;
        OP        = 2'b00;
        OUT_READY = 1'b0;

        #3;
        check("rst_in_ready", {31'b0, IN_READY}, 32'd1);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_result", {24'b0, RESULT}, 32'h00);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        run_op("sra_96_2", 2'b10, 8'h96, 8'd2, 8'hE5, 2);
        run_op("sll_81_9", 2'b00, 8'h81, 8'd9, 8'h00, 8);
`ifdef SHIFT_EXEC_ROTATE_EN
        run_op("ror_81_9", 2'b11, 8'h81, 8'd9, 8'hC0, 1);
        run_op("ror_01_3", 2'b11, 8'h01, 8'd3, 8'h20, 3);
        run_op("ror_a5_8", 2'b11, 8'hA5, 8'd8, 8'hA5, 0);
`else
        run_op("ror_81_9", 2'b11, 8'h81, 8'd9, 8'h81, 0);
        run_op("ror_01_3", 2'b11, 8'h01, 8'd3, 8'h01, 0);
`endif
        run_op("srl_5a_0", 2'b01, 8'h5A, 8'd0, 8'h5A, 0);
        run_op("srl_80_3", 2'b01, 8'h80, 8'd3, 8'h10, 3);
        run_op("sra_40_200", 2'b10, 8'h40, 8'd200, 8'h00, 8);
        run_op("sra_80_255", 2'b10, 8'h80, 8'd255, 8'hFF, 8);
        run_op("sll_01_7", 2'b00, 8'h01, 8'd7, 8'h80, 7);

        // Back-pressure: hold DONE for 5 cycles while a new request is offered.
        IN_VALID = 1'b1; OP = 2'b00; OPERAND = 8'h03; AMOUNT = 8'd1;
        @(posedge CLK); #1;
        OP = 2'b01; OPERAND = 8'hFF; AMOUNT = 8'd0;
        @(posedge CLK); #1;
        check("hold_enter_valid", {31'b0, OUT_VALID}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check($sformatf("hold_result_%0d", i), {24'b0, RESULT}, 32'h06);
            check($sformatf("hold_valid_%0d", i), {31'b0, OUT_VALID}, 32'd1);
            check($sformatf("hold_in_ready_%0d", i), {31'b0, IN_READY}, 32'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        @(posedge CLK); #1;
        check("hold_after_valid", {31'b0, OUT_VALID}, 32'd0);
        check("hold_after_busy", {31'b0, BUSY}, 32'd0);
        check("hold_retain_result", {24'b0, RESULT}, 32'h06);

        // Reset mid-SHIFT discards the operation.
        IN_VALID = 1'b1; OP = 2'b00; OPERAND = 8'hFF; AMOUNT = 8'd6;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("mid_busy_before", {31'b0, BUSY}, 32'd1);
        RESET = 1'b0;
        #1;
        check("mid_rst_result", {24'b0, RESULT}, 32'h00);
        check("mid_rst_busy", {31'b0, BUSY}, 32'd0);
        check("mid_rst_in_ready", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        check("mid_no_out_valid", seen, 0);
        check("mid_after_result", {24'b0, RESULT}, 32'h00);
        check("mid_after_in_ready", {31'b0, IN_READY}, 32'd1);

        run_op("post_rst_srl", 2'b01, 8'hF0, 8'd4, 8'h0F, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
